// File: rtl/stq_ring_ctl_pkg.sv
// Shared store-queue constants, pointer type and modular pointer arithmetic.
package stq_ring_ctl_pkg;
  localparam int STQ_BUF_COUNT = 64;
  localparam int STQ_IDX_W     = 6;

  // Top bit is the wrap bit, so full (distance BUF_COUNT) and empty (0) differ.
  typedef logic [STQ_IDX_W:0] stq_ptr_t;

  function automatic stq_ptr_t ptr_dist(input stq_ptr_t a, input stq_ptr_t b);
    return a - b;
  endfunction
endpackage

// File: rtl/stq_range_mask.sv
// Wrapped range mask: bit i set when index i lies in [start_ptr, end_ptr).
module stq_range_mask
  import stq_ring_ctl_pkg::*;
#(
  parameter int BUF_COUNT = STQ_BUF_COUNT,
  parameter int IDX_W     = STQ_IDX_W
) (
  input  logic [IDX_W:0]     start_ptr,
  input  logic [IDX_W:0]     end_ptr,
  input  logic               en,
  output logic [BUF_COUNT-1:0] mask
);
  logic [IDX_W:0] len;

  // len is IDX_W+1 bits so a range covering every entry still compares true.
  assign len = end_ptr - start_ptr;

  for (genvar i = 0; i < BUF_COUNT; i++) begin : g_bit
    logic [IDX_W-1:0] off;
    assign off     = IDX_W'(i) - start_ptr[IDX_W-1:0];
    assign mask[i] = en & ({1'b0, off} < len);
  end
endmodule

// File: rtl/stq_ring_ctl.sv
// Store-queue ring controller: dual allocate, dual retire, single drain, flush.
module stq_ring_ctl
  import stq_ring_ctl_pkg::*;
#(
  parameter int BUF_COUNT = STQ_BUF_COUNT,
  parameter int IDX_W     = STQ_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallA,
  input  logic                 excpt,
  input  logic                 alloc0_req,
  input  logic                 alloc1_req,
  output logic                 alloc_gnt,
  output logic [IDX_W-1:0]     alloc0_idx,
  output logic [IDX_W-1:0]     alloc1_idx,
  output logic [BUF_COUNT-1:0] wrt0_en,
  output logic [BUF_COUNT-1:0] wrt1_en,
  input  logic [1:0]           retire_cnt,
  output logic [BUF_COUNT-1:0] passe_en,
  output logic                 drain_valid,
  output logic [IDX_W-1:0]     drain_idx,
  input  logic                 drain_ready,
  output logic [BUF_COUNT-1:0] free_en,
  output logic [IDX_W:0]       occupancy,
  output logic                 full,
  output logic                 empty
);
  logic [IDX_W:0]     head, ret, tail;
  logic [IDX_W:0]     occ, unret, retd, space, ret_end;
  logic [1:0]         req, rc, eff;
  logic               gnt, fire;
  logic [BUF_COUNT-1:0] flush_mask;

  assign occ   = ptr_dist(tail, head);
  assign unret = ptr_dist(tail, ret);
  assign retd  = ptr_dist(ret, head);

  // Lane 1 only counts when lane 0 is also requesting.
  assign req   = {alloc0_req & alloc1_req, alloc0_req & ~alloc1_req};
  assign space = (IDX_W+1)'(BUF_COUNT) - occ;
  assign gnt   = rst & (req != 2'd0) & ~stallA & ~excpt & (space >= (IDX_W+1)'(req));

  assign alloc_gnt  = gnt;
  assign alloc0_idx = tail[IDX_W-1:0];
  assign alloc1_idx = alloc0_idx + IDX_W'(1);
  assign wrt0_en    = gnt ? (BUF_COUNT'(1) << alloc0_idx) : '0;
  assign wrt1_en    = (gnt & alloc1_req) ? (BUF_COUNT'(1) << alloc1_idx) : '0;

  always_comb begin
    rc  = (retire_cnt == 2'd3) ? 2'd2 : retire_cnt;
    eff = 2'd0;
    if (rst & ~excpt)
      eff = (unret < (IDX_W+1)'(rc)) ? unret[1:0] : rc;
  end

  assign ret_end = ret + (IDX_W+1)'(eff);

  stq_range_mask #(.BUF_COUNT(BUF_COUNT), .IDX_W(IDX_W)) u_passe (
    .start_ptr (ret),
    .end_ptr   (ret_end),
    .en        (rst),
    .mask      (passe_en)
  );

  stq_range_mask #(.BUF_COUNT(BUF_COUNT), .IDX_W(IDX_W)) u_flush (
    .start_ptr (ret),
    .end_ptr   (tail),
    .en        (rst & excpt),
    .mask      (flush_mask)
  );

  // Drain depends only on head/ret, so alloc and flush never disturb it.
  assign drain_valid = rst & (retd != '0);
  assign drain_idx   = head[IDX_W-1:0];
  assign fire        = drain_valid & drain_ready;
  assign free_en     = flush_mask | (fire ? (BUF_COUNT'(1) << drain_idx) : '0);

  assign occupancy = occ;
  assign full      = (occ == (IDX_W+1)'(BUF_COUNT));
  assign empty     = (occ == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      ret  <= '0;
      tail <= '0;
    end else begin
      head <= head + (IDX_W+1)'(fire);
      ret  <= ret_end;
      tail <= excpt ? ret : tail + (gnt ? (IDX_W+1)'(req) : '0);
    end
  end
endmodule

// File: tb/tb_stq_ring_ctl.sv
// Directed + random bench for stq_ring_ctl against an unbounded-integer pointer model.
module tb_stq_ring_ctl;
  logic        clk = 1'b0, rst = 1'b0;
  logic        stallA = 0, excpt = 0, alloc0_req = 0, alloc1_req = 0, drain_ready = 0;
  logic [1:0]  retire_cnt = 0;
  logic        alloc_gnt, drain_valid, full, empty;
  logic [5:0]  alloc0_idx, alloc1_idx, drain_idx;
  logic [63:0] wrt0_en, wrt1_en, passe_en, free_en;
  logic [6:0]  occupancy;

  int n_chk = 0, n_fail = 0;
  int m_head = 0, m_ret = 0, m_tail = 0;
  bit m_rst = 0;
  int n_head, n_ret, n_tail;

  stq_ring_ctl dut (
    .clk(clk), .rst(rst), .stallA(stallA), .excpt(excpt),
    .alloc0_req(alloc0_req), .alloc1_req(alloc1_req), .alloc_gnt(alloc_gnt),
    .alloc0_idx(alloc0_idx), .alloc1_idx(alloc1_idx),
    .wrt0_en(wrt0_en), .wrt1_en(wrt1_en), .retire_cnt(retire_cnt),
    .passe_en(passe_en), .drain_valid(drain_valid), .drain_idx(drain_idx),
    .drain_ready(drain_ready), .free_en(free_en), .occupancy(occupancy),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, then compare every output with the model.
  task automatic set(input bit a0, input bit a1, input bit st, input bit ex,
                     input int rcnt, input bit rdy);
    int occ, unret, retd, req, r, eff;
    bit e_gnt, e_dv, fire;
    logic [63:0] e_w0, e_w1, e_ps, e_fr;
    alloc0_req = a0; alloc1_req = a1; stallA = st; excpt = ex;
    retire_cnt = 2'(rcnt); drain_ready = rdy;
    #1;
    occ   = m_tail - m_head;
    unret = m_tail - m_ret;
    retd  = m_ret - m_head;
    req   = a0 ? (a1 ? 2 : 1) : 0;
    e_gnt = m_rst && req != 0 && !st && !ex && (64 - occ >= req);
    e_w0  = e_gnt ? (64'd1 << (m_tail % 64)) : 64'd0;
    e_w1  = (e_gnt && a1) ? (64'd1 << ((m_tail + 1) % 64)) : 64'd0;
    r     = (rcnt > 2) ? 2 : rcnt;
    eff   = (!m_rst || ex) ? 0 : (r < unret ? r : unret);
    e_ps  = 64'd0;
    for (int k = 0; k < eff; k++) e_ps[(m_ret + k) % 64] = 1'b1;
    e_dv  = m_rst && retd > 0;
    fire  = e_dv && rdy;
    e_fr  = 64'd0;
    if (m_rst && ex) for (int k = 0; k < unret; k++) e_fr[(m_ret + k) % 64] = 1'b1;
    if (fire) e_fr[m_head % 64] = 1'b1;

    chk("alloc_gnt", 64'(alloc_gnt), 64'(e_gnt));
    chk("alloc0_idx", 64'(alloc0_idx), 64'(m_tail % 64));
    chk("alloc1_idx", 64'(alloc1_idx), 64'((m_tail + 1) % 64));
    chk("wrt0_en", wrt0_en, e_w0);
    chk("wrt1_en", wrt1_en, e_w1);
    chk("passe_en", passe_en, e_ps);
    chk("drain_valid", 64'(drain_valid), 64'(e_dv));
    chk("drain_idx", 64'(drain_idx), 64'(m_head % 64));
    chk("free_en", free_en, e_fr);
    chk("occupancy", 64'(occupancy), 64'(occ));
    chk("full", 64'(full), 64'(occ == 64));
    chk("empty", 64'(empty), 64'(occ == 0));

    n_head = m_head + (fire ? 1 : 0);
    n_ret  = m_ret + eff;
    n_tail = !m_rst ? 0 : (ex ? m_ret : m_tail + (e_gnt ? req : 0));
    if (!m_rst) begin n_head = 0; n_ret = 0; end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    m_head = n_head; m_ret = n_ret; m_tail = n_tail;
  endtask

  // Steer the model pointers to ret == r_tgt, tail == t_tgt while draining.
  task automatic go_to(input int r_tgt, input int t_tgt);
    int i;
    for (i = 0; i < 400 && !(m_ret == r_tgt && m_tail == t_tgt); i++) begin
      set(m_tail < t_tgt, (t_tgt - m_tail) >= 2, 0, 0,
          (r_tgt - m_ret) >= 2 ? 2 : r_tgt - m_ret, 1);
      tick();
    end
    n_chk++;
    assert (m_ret == r_tgt && m_tail == t_tgt) else begin
      n_fail++;
      $error("FAIL go_to_timeout got=%0d/%0d exp=%0d/%0d", m_ret, m_tail, r_tgt, t_tgt);
    end
  endtask

  task automatic drain_all();
    int i;
    for (i = 0; i < 200 && m_head != m_ret; i++) begin
      set(0, 0, 0, 0, 0, 1);
      tick();
    end
    n_chk++;
    assert (m_head == m_ret) else begin
      n_fail++;
      $error("FAIL drain_timeout got=%0d exp=%0d", m_head, m_ret);
    end
  endtask

  initial begin
    // Reset state, with requests asserted to prove they are masked.
    set(1, 1, 0, 1, 2, 1);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_gnt", 64'(alloc_gnt), 64'd0);
    tick();
    rst = 1'b1; m_rst = 1;

    // Fill all 64 entries two per cycle.
    for (int i = 0; i < 32; i++) begin
      set(1, 1, 0, 0, 0, 0);
      chk("fill_w0", wrt0_en, 64'd1 << (2 * i));
      chk("fill_w1", wrt1_en, 64'd1 << (2 * i + 1));
      tick();
    end
    set(1, 0, 0, 0, 0, 0);
    chk("full_flag", 64'(full), 64'd1);
    chk("full_occ", 64'(occupancy), 64'd64);
    chk("full_gnt", 64'(alloc_gnt), 64'd0);
    tick();

    // Retire two, then hold the drain under backpressure.
    set(0, 0, 0, 0, 2, 0);
    chk("passe_first", passe_en, 64'h3);
    tick();
    for (int i = 0; i < 3; i++) begin
      set(0, 0, 0, 0, 0, 0);
      chk("bp_valid", 64'(drain_valid), 64'd1);
      chk("bp_idx", 64'(drain_idx), 64'd0);
      tick();
    end
    set(0, 0, 0, 0, 0, 1);
    chk("drain_free0", free_en, 64'h1);
    tick();

    // Occupancy 63: alloc 1 + retire 2 + drain accept in one cycle.
    set(1, 0, 0, 0, 2, 1);
    chk("sim_idx", 64'(drain_idx), 64'd1);
    chk("sim_gnt", 64'(alloc_gnt), 64'd1);
    chk("sim_free", free_en, 64'h2);
    chk("sim_wrt0", wrt0_en, 64'h1);
    chk("sim_disjoint", free_en & wrt0_en, 64'd0);
    tick();
    chk("sim_occ", 64'(occupancy), 64'd63);

    // Wrap: bring all pointers to 62, then allocate across the boundary.
    go_to(126, 126);
    drain_all();
    set(1, 1, 0, 0, 0, 0);
    chk("wrap_i0", 64'(alloc0_idx), 64'd62);
    chk("wrap_i1", 64'(alloc1_idx), 64'd63);
    tick();
    set(1, 1, 0, 0, 0, 0);
    chk("wrap_i2", 64'(alloc0_idx), 64'd0);
    chk("wrap_i3", 64'(alloc1_idx), 64'd1);
    tick();
    set(0, 0, 0, 0, 2, 0);
    chk("wrap_passe", passe_en, 64'hC000_0000_0000_0000);
    tick();

    // Exception with ret at 60 and eight unretired entries wrapping to 3.
    go_to(188, 196);
    set(1, 1, 0, 1, 2, 0);
    chk("excpt_free", free_en, 64'hF000_0000_0000_000F);
    chk("excpt_gnt", 64'(alloc_gnt), 64'd0);
    chk("excpt_passe", passe_en, 64'd0);
    tick();
    set(0, 0, 0, 0, 0, 0);
    chk("excpt_tail", 64'(alloc0_idx), 64'd60);
    tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      set($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
          $urandom_range(7, 0) == 0, $urandom_range(31, 0) == 0,
          int'($urandom_range(3, 0)), $urandom_range(3, 0) != 0);
      tick();
    end
    go_to(m_ret, m_tail + 4);

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b0; m_rst = 0; m_head = 0; m_ret = 0; m_tail = 0;
    set(1, 1, 0, 1, 2, 1);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_free", free_en, 64'd0);
    chk("arst_valid", 64'(drain_valid), 64'd0);
    tick();
    #2;
    rst = 1'b1; m_rst = 1;
    set(0, 0, 0, 0, 0, 0);
    chk("post_empty", 64'(empty), 64'd1);
    chk("post_idx", 64'(alloc0_idx), 64'd0);
    tick();
    for (int i = 0; i < 100; i++) begin
      set($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, 0,
          $urandom_range(15, 0) == 0, int'($urandom_range(3, 0)),
          $urandom_range(1, 0) == 1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stq_ring_ctl.md
Name: stq_ring_ctl

Overview:
- Pointer and handshake controller that drives the per-entry control vectors of the 64-entry store-queue address buffer array: wrt0_en, wrt1_en, passe_en and free_en.
- Allocates up to two entries per cycle at dispatch and marks up to two of the oldest entries as retired (passe) per cycle.
- Drains retired entries to the cache write path over a valid/ready handshake.
- On an exception, reclaims every allocated entry that has not yet retired.

Parameters:
- BUF_COUNT, 64, number of store-queue entries; must be a power of two.
- IDX_W, 6, log2(BUF_COUNT).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
- stallA  in  1  blocks allocation this cycle
- excpt  in  1  flush of all unretired entries
- alloc0_req  in  1  request lane 0 entry
- alloc1_req  in  1  request lane 1 entry; honoured only together with alloc0_req
- alloc_gnt  out  1  allocation accepted this cycle
- alloc0_idx  out  IDX_W  entry index given to lane 0
- alloc1_idx  out  IDX_W  entry index given to lane 1
- wrt0_en  out  BUF_COUNT  one-hot write enable, lane 0
- wrt1_en  out  BUF_COUNT  one-hot write enable, lane 1
- retire_cnt  in  2  number of oldest stores retiring (0..2)
- passe_en  out  BUF_COUNT  retire mask (0 to 2 bits set)
- drain_valid  out  1  oldest retired entry is ready to write to cache
- drain_idx  out  IDX_W  index of that entry
- drain_ready  in  1  cache write port accepts the entry
- free_en  out  BUF_COUNT  entries freed this cycle
- occupancy  out  IDX_W+1  number of allocated entries, 0..BUF_COUNT
- full  out  1  occupancy == BUF_COUNT
- empty  out  1  occupancy == 0

Behaviour:
- Three pointers, each IDX_W+1 bits wide with the top bit as the wrap bit:
  - head: oldest entry not yet drained.
  - ret: oldest entry not yet retired.
  - tail: next entry to allocate.
- Invariant: head <= ret <= tail in modular order. occupancy = tail - head, unret = tail - ret, retd = ret - head, all computed modulo 2^(IDX_W+1).
- Reset (rst = 0, asynchronous): all pointers 0, occupancy 0, empty = 1, full = 0. While rst = 0, every *_en vector, alloc_gnt and drain_valid is forced to 0.
- Allocation, combinational grant with pointer update on the clock edge:
  - req = alloc0_req + (alloc0_req & alloc1_req).
  - alloc_gnt = (req != 0) & ~stallA & ~excpt & (BUF_COUNT - occupancy >= req). Grant is all-or-nothing; there is no partial grant.
  - alloc0_idx = tail[IDX_W-1:0], alloc1_idx = (tail + 1)[IDX_W-1:0]; the index wraps 63 -> 0.
  - wrt0_en = onehot(alloc0_idx) when alloc_gnt is set, else 0. wrt1_en = onehot(alloc1_idx) when alloc_gnt & alloc1_req, else 0.
  - On the edge, tail += req if alloc_gnt is set.
- Retire:
  - eff = min(retire_cnt, unret); retire_cnt = 3 is treated as 2. eff = 0 whenever excpt = 1.
  - passe_en sets the bits for ret and ret+1 (wrapped), according to eff.
  - On the edge, ret += eff.
- Drain:
  - drain_valid = (retd != 0), drain_idx = head[IDX_W-1:0].
  - On drain_valid & drain_ready: the head bit is set in free_en and head increments on the edge.
  - drain_valid and drain_idx must stay stable until accepted; neither alloc nor excpt changes them.
- Exception:
  - excpt = 1 sets free_en for every index in [ret, tail), wrapped; this is OR-ed with any drain free bit in the same cycle. On the edge, tail <= ret.
  - Allocation and retire are suppressed that cycle; drain proceeds normally.
- Simultaneous events:
  - Alloc, retire and drain may all occur in one cycle. occupancy updates by +req - drained.
  - Alloc into the slot being drained in the same cycle is impossible: it would require occupancy == BUF_COUNT, and the grant is then refused.
- Full: with occupancy 63, a 2-entry request is refused and a 1-entry request is granted.

Decomposition:
- A shared lsq package holds:
  - the constants STQ_BUF_COUNT = 64 and STQ_IDX_W = 6;
  - the typedef stq_ptr_t (IDX_W+1 bits);
  - the function ptr_dist(a, b) for modular pointer distance.
- One sub-module, stq_range_mask: given a start pointer, an end pointer and an enable, it produces the BUF_COUNT-bit wrapped range mask. It is used for the excpt free_en mask and, with end = start + eff, for passe_en.

Test Plan:
- Reset then fill: 32 cycles of alloc0 + alloc1 -> indices 0..63, with wrt enables one-hot at each index. After 32 cycles, full = 1 and occupancy = 64. The next request gives alloc_gnt = 0.
- Retire and drain with backpressure: retire_cnt = 2 -> passe_en = 0x3. Hold drain_ready = 0 for 3 cycles -> drain_valid = 1 and drain_idx = 0 stay stable. Raise ready -> free_en = 0x1 in that cycle, then drain_idx = 1.
- Wrap: with head = ret = tail = 62, alloc two, then two more -> indices 62, 63, 0, 1. Retire 2 -> passe_en bits 62 and 63.
- Exception: with ret = 60, tail = 68 (wrap, indices 60..63, 0..3) -> free_en = 0xF00000000000000F. Next cycle tail = 60, and an alloc in the excpt cycle is refused.
- Simultaneous events at occupancy 63: alloc 1 + retire 2 + drain accept -> grant = 1, occupancy stays 63, and free_en and wrt0_en select different bits.
- Asynchronous reset mid-operation: drop rst between clock edges -> all enables are 0 immediately. After release, empty = 1 and alloc0_idx = 0.
